novacore_cfg_loader: RTL and testbench

Hardware configuration sequencer for the NovaCORE fabric. Consumes a stream of 32-bit configuration words (from an on-chip ROM or FIFO) and drives the fabric configuration port (`mode`, `c_bus`, `c_uid`, `c_clk`, `c_dimension`, `c_dimswitch`), replacing the soft-processor blaster for stand-alone boot. Sits between the configuration source and the `NovaCORE` instance in the top level, in the fabric clock domain.

---
 rtl/novacore_cfg_loader.sv | 146 ++++++++++++++
 tb/tb_novacore_cfg_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/novacore_cfg_loader.sv
// novacore_cfg_loader: stand-alone configuration sequencer for the NovaCORE fabric.
// It reads a stream of 32-bit header/data words and drives the fabric configuration
// port. Each DIM header or LOAD data word produces one c_clk pulse: CLK_HALF cycles
// low, then CLK_HALF cycles high. The data outputs stay stable for the whole pulse.
module novacore_cfg_loader #(
  parameter int unsigned BUS_W    = 28,
  parameter int unsigned UID_W    = 4,
  parameter int unsigned DIM_W    = 4,
  parameter int unsigned CLK_HALF = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             mode,
  output logic [BUS_W-1:0] c_bus,
  output logic [UID_W-1:0] c_uid,
  output logic             c_clk,
  output logic [DIM_W-1:0] c_dimension,
  output logic             c_dimswitch,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FETCH_HDR  = 3'd1;
  localparam logic [2:0] ST_FETCH_DATA = 3'd2;
  localparam logic [2:0] ST_CLK_LO     = 3'd3;
  localparam logic [2:0] ST_CLK_HI     = 3'd4;

  localparam logic [3:0] OP_DIM  = 4'h1;
  localparam logic [3:0] OP_LOAD = 4'h2;
  localparam logic [3:0] OP_END  = 4'hF;

  localparam logic [7:0] HALF_LAST = 8'(CLK_HALF - 1);

  logic [2:0]  state;
  logic [15:0] remain;
  logic [7:0]  phase;
  logic        in_load;
  logic [3:0]  opcode;
  logic [15:0] arg;

  assign opcode = s_data[31:28];
  assign arg    = s_data[15:0];

  // Handshake and status outputs depend only on the current state.
  always_comb begin
    s_ready = (state == ST_FETCH_HDR) || (state == ST_FETCH_DATA);
    busy    = (state != ST_IDLE);
  end

  // Sequencer: fetch words, decode headers, and time the c_clk pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      remain      <= '0;
      phase       <= '0;
      in_load     <= 1'b0;
      mode        <= 1'b1;
      c_bus       <= '0;
      c_uid       <= '0;
      c_clk       <= 1'b0;
      c_dimension <= '0;
      c_dimswitch <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode  <= 1'b1;
            err   <= 1'b0;
            state <= ST_FETCH_HDR;
          end
        end
        ST_FETCH_HDR: begin
          if (s_valid) begin
            case (opcode)
              OP_DIM: begin
                c_dimension <= s_data[DIM_W-1:0];
                c_dimswitch <= 1'b1;
                in_load     <= 1'b0;
                phase       <= '0;
                state       <= ST_CLK_LO;
              end
              OP_LOAD: begin
                c_uid   <= UID_W'(s_data[27:24]);
                remain  <= arg;
                in_load <= (arg != 16'd0);
                state   <= (arg == 16'd0) ? ST_FETCH_HDR : ST_FETCH_DATA;
              end
              OP_END: begin
                mode  <= 1'b0;
                done  <= 1'b1;
                state <= ST_IDLE;
              end
              default: begin
                err   <= 1'b1;
                state <= ST_IDLE;
              end
            endcase
          end
        end
        ST_FETCH_DATA: begin
          if (s_valid) begin
            c_bus  <= s_data[BUS_W-1:0];
            remain <= remain - 16'd1;
            phase  <= '0;
            state  <= ST_CLK_LO;
          end
        end
        ST_CLK_LO: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            c_clk <= 1'b1;
            state <= ST_CLK_HI;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_CLK_HI: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            c_clk <= 1'b0;
            if (in_load && (remain != 16'd0)) begin
              state <= ST_FETCH_DATA;
            end else begin
              c_dimswitch <= 1'b0;
              in_load     <= 1'b0;
              state       <= ST_FETCH_HDR;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// Testbench for novacore_cfg_loader. It runs directed and randomized configuration
// programs. Expected pulses are derived from the opcode rules applied to the word list.
module tb_novacore_cfg_loader;

  localparam int unsigned HALF  = 2;
  localparam int unsigned BOUND = 200;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        mode;
  logic [27:0] c_bus;
  logic [3:0]  c_uid;
  logic        c_clk;
  logic [3:0]  c_dimension;
  logic        c_dimswitch;
  logic        busy;
  logic        done;
  logic        err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc = 0, last_acc = 0, rise_cyc = 0, done_hi = 0;
  logic        prev_clk = 1'b0;
  logic [36:0] hold_v = '0;
  logic [36:0] cap_q[$];
  logic [31:0] acc_q[$];
  int unsigned acc_cyc[$];
  logic [31:0] prog[$];
  logic [27:0] m_bus;
  logic [3:0]  m_uid, m_dim;

  always #5 clk = ~clk;

  novacore_cfg_loader #(
    .BUS_W(28), .UID_W(4), .DIM_W(4), .CLK_HALF(HALF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .mode(mode), .c_bus(c_bus), .c_uid(c_uid), .c_clk(c_clk),
    .c_dimension(c_dimension), .c_dimswitch(c_dimswitch), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Log every stream transfer and the edge number at which it happened.
  always @(posedge clk) begin
    if (s_valid && s_ready) begin
      acc_q.push_back(s_data);
      acc_cyc.push_back(cyc + 1);
      last_acc = cyc + 1;
    end
    cyc = cyc + 1;
  end

  // Capture c_clk pulses and check pulse timing and data hold.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_clk = 1'b0;
    end else begin
      if (c_clk && !prev_clk) begin
        hold_v = {c_bus, c_uid, c_dimension, c_dimswitch};
        cap_q.push_back(hold_v);
        check("rise_delay", cyc - last_acc, HALF);
        rise_cyc = cyc;
      end
      if (c_clk && prev_clk)
        check("hold_high", {c_bus, c_uid, c_dimension, c_dimswitch}, hold_v);
      if (!c_clk && prev_clk)
        check("high_width", cyc - rise_cyc, HALF);
      if (done) done_hi++;
      prev_clk = c_clk;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_mode"}, mode, 1);
    check({tag, "_c_bus"}, c_bus, 0);
    check({tag, "_c_uid"}, c_uid, 0);
    check({tag, "_c_clk"}, c_clk, 0);
    check({tag, "_c_dim"}, c_dimension, 0);
    check({tag, "_c_dimsw"}, c_dimswitch, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_s_ready"}, s_ready, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_s_ready", s_ready, 1);
    check("start_err_clr", err, 0);
    check("start_mode", mode, 1);
  endtask

  task automatic push(input logic [31:0] w, input int unsigned gap);
    int unsigned t;
    for (int unsigned g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      start   = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    t = 0;
    while (!s_ready && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", (t < BOUND), 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  // Expected pulses come from walking the program with the opcode rules.
  task automatic run_prog(input int unsigned gmin, input int unsigned gmax, input string nm);
    logic [36:0] exp_q[$];
    int unsigned i, n, lim;
    logic [31:0] h;
    bit ended_ok, ended_err;
    i = 0; ended_ok = 0; ended_err = 0;
    while (i < prog.size() && !ended_ok && !ended_err) begin
      h = prog[i];
      i++;
      case (h[31:28])
        4'h1: begin
          m_dim = h[3:0];
          exp_q.push_back({m_bus, m_uid, m_dim, 1'b1});
        end
        4'h2: begin
          m_uid = h[27:24];
          n = h[15:0];
          for (int unsigned k = 0; k < n; k++) begin
            m_bus = prog[i][27:0];
            i++;
            exp_q.push_back({m_bus, m_uid, m_dim, 1'b0});
          end
        end
        4'hF: ended_ok = 1;
        default: ended_err = 1;
      endcase
    end
    cap_q.delete(); acc_q.delete(); acc_cyc.delete(); done_hi = 0;
    do_start();
    foreach (prog[k]) push(prog[k], $urandom_range(gmin, gmax));
    check({nm, "_end_busy"}, busy, 0);
    check({nm, "_end_mode"}, mode, ended_ok ? 0 : 1);
    check({nm, "_end_done"}, done, ended_ok ? 1 : 0);
    check({nm, "_end_err"}, err, ended_err ? 1 : 0);
    @(negedge clk);
    check({nm, "_done_low"}, done, 0);
    check({nm, "_done_cycles"}, done_hi, ended_ok ? 1 : 0);
    check({nm, "_pulse_count"}, cap_q.size(), exp_q.size());
    lim = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int unsigned k = 0; k < lim; k++) check({nm, "_pulse_data"}, cap_q[k], exp_q[k]);
    check({nm, "_xfer_count"}, acc_q.size(), prog.size());
    lim = (acc_q.size() < prog.size()) ? acc_q.size() : prog.size();
    for (int unsigned k = 0; k < lim; k++) check({nm, "_xfer_word"}, acc_q[k], prog[k]);
  endtask

  initial begin
    int unsigned t, nops, n;
    reset_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    m_bus = '0; m_uid = '0; m_dim = '0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset("idle");

    // Valid without start must not transfer.
    s_valid = 1'b1; s_data = 32'h2500_0003;
    repeat (5) @(negedge clk);
    check("idle_no_xfer", acc_q.size(), 0);
    check("idle_s_ready", s_ready, 0);
    check("idle_busy", busy, 0);
    s_valid = 1'b0;

    // DIM then END.
    prog.delete();
    prog.push_back(32'h1000_0003); prog.push_back(32'hF000_0000);
    run_prog(0, 0, "dim");
    check("dim_value", c_dimension, 3);
    check("dim_switch_cleared", c_dimswitch, 0);

    // LOAD of three words, back to back.
    prog.delete();
    prog.push_back(32'h2500_0003); prog.push_back(32'h0ABC_DEF1);
    prog.push_back(32'h0000_0002); prog.push_back(32'h0FFF_FFFF);
    prog.push_back(32'hF000_0000);
    run_prog(0, 0, "load3");
    check("load3_uid", c_uid, 5);
    if (acc_cyc.size() >= 4) begin
      check("load3_rate_a", acc_cyc[2] - acc_cyc[1], 2 * HALF + 1);
      check("load3_rate_b", acc_cyc[3] - acc_cyc[2], 2 * HALF + 1);
    end else begin
      check("load3_acc_cycles", acc_cyc.size(), 4);
    end

    // LOAD of four words with s_valid dropping between words.
    prog.delete();
    prog.push_back(32'h2A00_0004);
    repeat (4) prog.push_back($urandom);
    prog.push_back(32'hF000_0000);
    run_prog(1, 1, "toggle4");

    // LOAD with zero words.
    prog.delete();
    prog.push_back(32'h2300_0000); prog.push_back(32'hF000_0000);
    run_prog(0, 0, "arg0");

    // Illegal opcode. The next start must clear err.
    prog.delete();
    prog.push_back(32'h7000_0000);
    run_prog(0, 0, "illegal");

    // Randomized programs.
    for (int r = 0; r < 10; r++) begin
      prog.delete();
      nops = $urandom_range(1, 4);
      repeat (nops) begin
        if ($urandom_range(0, 2) == 0) begin
          prog.push_back({4'h1, 24'($urandom), 4'($urandom)});
        end else begin
          n = $urandom_range(0, 4);
          prog.push_back({4'h2, 4'($urandom), 8'($urandom), 16'(n)});
          repeat (n) prog.push_back($urandom);
        end
      end
      if ($urandom_range(0, 4) == 0) prog.push_back({4'($urandom_range(3, 14)), 28'($urandom)});
      else prog.push_back({4'hF, 28'($urandom)});
      run_prog(0, 3, "rand");
    end

    // Asynchronous reset during the high phase of a LOAD pulse.
    do_start();
    push(32'h2100_0002, 0);
    push(32'h0123_4567, 0);
    t = 0;
    while (!c_clk && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    check("rst_wait_hi", (t < BOUND), 1);
    #2 reset_n = 1'b0;
    #1 check_reset("async_rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_bus = '0; m_uid = '0; m_dim = '0;
    @(negedge clk);
    prog.delete();
    prog.push_back(32'h2900_0001); prog.push_back($urandom); prog.push_back(32'hF000_0000);
    run_prog(0, 2, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
